rv32_register_file: RTL and testbench



---
 rtl/rv32_register_file_if.sv | 47 ++++
 rtl/rv32_register_file.sv | 55 +++++
 tb/tb_rv32_register_file.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_register_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_register_file_if
//  Description : Write/read bus between the decode/writeback logic and the
//                RV32I integer register file.
//                  wr_en / wr_reg / wr_data     : single synchronous write port
//                  rd_reg_1 / rd_data_1         : asynchronous read port 1 (rs1)
//                  rd_reg_2 / rd_data_2         : asynchronous read port 2 (rs2)
//                Modport "master" is the pipeline side, "slave" the register
//                file itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rv32_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_reg;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_reg_1;
    logic [ADDR_WIDTH-1:0] rd_reg_2;
    logic [DATA_WIDTH-1:0] rd_data_1;
    logic [DATA_WIDTH-1:0] rd_data_2;

    modport master (
        output wr_en,
        output wr_reg,
        output wr_data,
        output rd_reg_1,
        output rd_reg_2,
        input  rd_data_1,
        input  rd_data_2
    );

    modport slave (
        input  wr_en,
        input  wr_reg,
        input  wr_data,
        input  rd_reg_1,
        input  rd_reg_2,
        output rd_data_1,
        output rd_data_2
    );

endinterface
`default_nettype wire

// File: rtl/rv32_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_register_file
//  Description : RV32I integer register file, NUM_REGS x DATA_WIDTH.
//                Two combinational read ports, one write port updated on the
//                rising clock edge. x0 is hardwired to zero: it has no storage
//                and writes addressed to it are dropped.
//  Ports       : clk    - system clock, rising edge
//                rst_n  - asynchronous active-low reset, clears x1..x31
//                bus    - rv32_register_file_if.slave (write + two reads)
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    rv32_register_file_if.slave   bus
);

    // Read-mux source array. Entry 0 is a constant zero so the read muxes need
    // no special case for x0; entries 1.. come from the per-register flops.
    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

    assign w_regs[0] = '0;

    generate
        for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
            logic                  w_hit;
            logic [DATA_WIDTH-1:0] r_value;

            // Index 0 can never match here, so writes to x0 fall away naturally.
            assign w_hit = bus.wr_en && (bus.wr_reg == ADDR_WIDTH'(g));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_value <= '0;
                end else if (w_hit) begin
                    r_value <= bus.wr_data;
                end
            end

            assign w_regs[g] = r_value;
        end
    endgenerate

    // No write-to-read bypass: a read of the register being written returns
    // the stored (old) value until the clock edge commits the new one.
    assign bus.rd_data_1 = w_regs[bus.rd_reg_1];
    assign bus.rd_data_2 = w_regs[bus.rd_reg_2];

endmodule
`default_nettype wire

// File: tb/tb_rv32_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_register_file
//  Description : Self-checking bench for rv32_register_file. Directed scenarios
//                followed by randomized transactions checked against an
//                array-based reference register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_register_file;

    logic clk;
    logic rst_n;

    rv32_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_if ();

    rv32_register_file #(
        .DATA_WIDTH (32),
        .NUM_REGS   (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference architectural state: x0 reads as zero, everything else holds
    // the last value written since reset.
    logic [31:0] model [32];
    int          total;
    int          passed;

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : model[idx];
    endfunction

    function automatic void ref_write(input logic en, input logic [4:0] idx, input logic [31:0] d);
        if (en && idx != 5'd0) model[idx] = d;
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endfunction

    // Align to 1 ns after a rising edge: the drive point for every scenario.
    task automatic next_drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rf_if.wr_en = 1'b0; rf_if.wr_reg = '0; rf_if.wr_data = '0;
        rf_if.rd_reg_1 = 5'd0; rf_if.rd_reg_2 = 5'd0;
        ref_clear();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (rf_if.rd_data_1 !== 32'h0)
            $display("FAIL reset_rd1: got %h want %h", rf_if.rd_data_1, 32'h0);
        else passed++;
        total++;
        if (rf_if.rd_data_2 !== 32'h0)
            $display("FAIL reset_rd2: got %h want %h", rf_if.rd_data_2, 32'h0);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        next_drive_point();
        rf_if.wr_en = 1'b1; rf_if.wr_reg = 5'd5; rf_if.wr_data = 32'hDEADBEEF;
        rf_if.rd_reg_1 = 5'd5; rf_if.rd_reg_2 = 5'd5;
        #3;
        total++;
        if (rf_if.rd_data_1 !== 32'h0)
            $display("FAIL no_bypass_x5: got %h want %h", rf_if.rd_data_1, 32'h0);
        else passed++;
        @(posedge clk);
        ref_write(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        rf_if.wr_en = 1'b0;
        total++;
        if (rf_if.rd_data_1 !== 32'hDEADBEEF)
            $display("FAIL write_x5: got %h want %h", rf_if.rd_data_1, 32'hDEADBEEF);
        else passed++;
    endtask

    task automatic test_overwrite();
        next_drive_point();
        rf_if.wr_en = 1'b1; rf_if.wr_reg = 5'd15; rf_if.wr_data = 32'hFFFF0000;
        next_drive_point();
        ref_write(1'b1, 5'd15, 32'hFFFF0000);
        rf_if.wr_data = 32'h0000FFFF;
        next_drive_point();
        ref_write(1'b1, 5'd15, 32'h0000FFFF);
        rf_if.wr_en = 1'b0;
        rf_if.rd_reg_1 = 5'd15; rf_if.rd_reg_2 = 5'd15;
        #1;
        total++;
        if (rf_if.rd_data_1 !== 32'h0000FFFF)
            $display("FAIL overwrite_rd1: got %h want %h", rf_if.rd_data_1, 32'h0000FFFF);
        else passed++;
        total++;
        if (rf_if.rd_data_2 !== 32'h0000FFFF)
            $display("FAIL overwrite_rd2: got %h want %h", rf_if.rd_data_2, 32'h0000FFFF);
        else passed++;
    endtask

    task automatic test_x0();
        next_drive_point();
        rf_if.wr_en = 1'b1; rf_if.wr_reg = 5'd0; rf_if.wr_data = 32'hFFFFFFFF;
        rf_if.rd_reg_1 = 5'd0; rf_if.rd_reg_2 = 5'd0;
        next_drive_point();
        rf_if.wr_en = 1'b0;
        #1;
        total++;
        if (rf_if.rd_data_1 !== 32'h0)
            $display("FAIL x0_rd1: got %h want %h", rf_if.rd_data_1, 32'h0);
        else passed++;
        total++;
        if (rf_if.rd_data_2 !== 32'h0)
            $display("FAIL x0_rd2: got %h want %h", rf_if.rd_data_2, 32'h0);
        else passed++;
    endtask

    task automatic test_write_disable();
        next_drive_point();
        rf_if.wr_en = 1'b0; rf_if.wr_reg = 5'd20; rf_if.wr_data = 32'hFFFFFFFF;
        repeat (4) @(posedge clk);
        #1;
        rf_if.rd_reg_1 = 5'd20; rf_if.rd_reg_2 = 5'd5;
        #1;
        total++;
        if (rf_if.rd_data_1 !== ref_read(5'd20))
            $display("FAIL wr_dis_x20: got %h want %h", rf_if.rd_data_1, ref_read(5'd20));
        else passed++;
        total++;
        if (rf_if.rd_data_2 !== 32'hDEADBEEF)
            $display("FAIL persist_x5: got %h want %h", rf_if.rd_data_2, 32'hDEADBEEF);
        else passed++;
        rf_if.rd_reg_1 = 5'd15;
        #1;
        total++;
        if (rf_if.rd_data_1 !== 32'h0000FFFF)
            $display("FAIL persist_x15: got %h want %h", rf_if.rd_data_1, 32'h0000FFFF);
        else passed++;
    endtask

    task automatic test_random();
        logic        en;
        logic [4:0]  wr, r1, r2;
        logic [31:0] d;
        logic [31:0] e1, e2;
        for (int n = 0; n < 1000; n++) begin
            next_drive_point();
            en = 1'($urandom_range(0, 3) != 0);
            wr = 5'($urandom_range(0, 31));
            d  = $urandom;
            // Bias reads towards the write target to exercise the no-bypass rule.
            r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            rf_if.wr_en = en; rf_if.wr_reg = wr; rf_if.wr_data = d;
            rf_if.rd_reg_1 = r1; rf_if.rd_reg_2 = r2;
            #3;
            e1 = ref_read(r1);
            e2 = ref_read(r2);
            total++;
            if (rf_if.rd_data_1 !== e1)
                $display("FAIL rand_pre_rd1[%0d] x%0d: got %h want %h", n, r1, rf_if.rd_data_1, e1);
            else passed++;
            total++;
            if (rf_if.rd_data_2 !== e2)
                $display("FAIL rand_pre_rd2[%0d] x%0d: got %h want %h", n, r2, rf_if.rd_data_2, e2);
            else passed++;
            @(posedge clk);
            ref_write(en, wr, d);
            #1;
            e1 = ref_read(r1);
            total++;
            if (rf_if.rd_data_1 !== e1)
                $display("FAIL rand_post_rd1[%0d] x%0d: got %h want %h", n, r1, rf_if.rd_data_1, e1);
            else passed++;
        end
        rf_if.wr_en = 1'b0;
    endtask

    task automatic test_reset_midcycle();
        next_drive_point();
        rf_if.wr_en = 1'b1; rf_if.wr_reg = 5'd7; rf_if.wr_data = 32'hA5A5A5A5;
        #3;
        rst_n = 1'b0;
        ref_clear();
        // Sweep every register on both ports while reset is held; the sweep
        // crosses several rising edges with a write still requested.
        for (int k = 0; k < 32; k++) begin
            rf_if.rd_reg_1 = 5'(k);
            rf_if.rd_reg_2 = 5'(31 - k);
            #1;
            total++;
            if (rf_if.rd_data_1 !== 32'h0)
                $display("FAIL rst_mid_rd1 x%0d: got %h want %h", k, rf_if.rd_data_1, 32'h0);
            else passed++;
            total++;
            if (rf_if.rd_data_2 !== 32'h0)
                $display("FAIL rst_mid_rd2 x%0d: got %h want %h", 31 - k, rf_if.rd_data_2, 32'h0);
            else passed++;
        end
        rf_if.wr_en = 1'b0;
        next_drive_point();
        rst_n = 1'b1;
        rf_if.wr_en = 1'b1; rf_if.wr_reg = 5'd9; rf_if.wr_data = 32'h12345678;
        rf_if.rd_reg_1 = 5'd9; rf_if.rd_reg_2 = 5'd7;
        next_drive_point();
        ref_write(1'b1, 5'd9, 32'h12345678);
        rf_if.wr_en = 1'b0;
        #1;
        total++;
        if (rf_if.rd_data_1 !== ref_read(5'd9))
            $display("FAIL post_rst_write_x9: got %h want %h", rf_if.rd_data_1, ref_read(5'd9));
        else passed++;
        total++;
        if (rf_if.rd_data_2 !== ref_read(5'd7))
            $display("FAIL post_rst_x7: got %h want %h", rf_if.rd_data_2, ref_read(5'd7));
        else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_write_read();
        test_overwrite();
        test_x0();
        test_write_disable();
        test_random();
        test_reset_midcycle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
